// File: rtl/sub_serial_8bit_if.sv
// sub_serial_8bit_if: operand/result handshake bundle for the bit-serial subtractor.
//   master : drives in_valid, a, b, bin, out_ready; observes in_ready and the results.
//   slave  : drives in_ready, out_valid, diff, bout, zero, ovf.
interface sub_serial_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/sub_serial_8bit.sv
// sub_serial_8bit: bit-serial subtractor computing a - b - bin, LSB first, one bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sub_serial_8bit_if
//           in_valid/in_ready   operand handshake (a, b, bin)
//           out_valid/out_ready result handshake (diff, bout, zero, ovf)
// Results are registered and change only on entry to DONE or on reset.
module sub_serial_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    sub_serial_8bit_if.slave   bus
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
    logic [CntW-1:0]  cnt_q;
    logic             r_q, bout_q, zero_q, ovf_q;

    logic             x, y, d, r_next, last;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    always_comb begin
        x        = a_q[0];
        y        = b_q[0];
        d        = x ^ y ^ r_q;
        r_next   = (~x & y) | (~x & r_q) | (y & r_q);
        res_next = {d, res_q[WIDTH-1:1]};
        last     = (cnt_q == LastBit);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= 1'b0;
            res_q  <= '0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        r_q   <= bus.bin;
                        cnt_q <= '0;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    r_q   <= r_next;
                    res_q <= res_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last) begin
                        diff_q <= res_next;
                        bout_q <= r_next;
                        // r_q here is the borrow into the MSB
                        ovf_q  <= r_q ^ r_next;
                        zero_q <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;

endmodule
